delay_cal_ctrl: RTL and testbench

Synchronous calibration controller for the async core's matched-delay lines. It enables a ring oscillator built from a tap-selectable inverter-chain delay line and counts its edges over a fixed window of the system clock. It then walks the tap select upward until the measured delay meets a programmed target. The resulting tap select drives the matched-delay muxes in the bundled-data handshake paths.

---
 rtl/delay_cal_pkg.sv | 24 ++
 rtl/delay_cal_ctrl_osc_edge_counter.sv | 49 ++++
 rtl/delay_cal_ctrl.sv | 164 ++++++++++++++++
 tb/tb_delay_cal_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_cal_pkg.sv
// Shared types and default sizing for the matched-delay calibration controller.
package delay_cal_pkg;

    localparam int TAP_W_DEF         = 4;
    localparam int CNT_W_DEF         = 12;
    localparam int WIN_CYCLES_DEF    = 256;
    localparam int SETTLE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } cal_state_t;

    // Down-counter width able to hold max(win, settle) - 1.
    function automatic int timer_width(input int win, input int settle);
        int longest;
        longest = (win > settle) ? win : settle;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/delay_cal_ctrl_osc_edge_counter.sv
// Synchronises the free-running ring-oscillator output and counts its rising
// edges into a saturating counter while enabled.
module osc_edge_counter
    import delay_cal_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_osc,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;
    logic edge_seen;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= i_osc;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign edge_seen = sync_2 & ~sync_prev;

    // Saturate rather than wrap so a too-fast oscillator can never alias to a pass.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable && edge_seen && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/delay_cal_ctrl.sv
// Matched-delay calibration: steps the delay-line tap up until the ring-oscillator
// edge count per window meets the target. DELAY_CAL_MARGIN_EN adds one guard tap on lock.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for i_start; results from last run held
// ST_SETTLE  | oscillator enabled, counter cleared, waiting SETTLE_CYCLES
// ST_MEASURE | counting oscillator edges for WIN_CYCLES
// ST_COMPARE | compare count to target; lock, fail or advance the tap
// ST_DONE    | one-cycle o_done pulse, then back to idle
module delay_cal_ctrl
    import delay_cal_pkg::*;
#(
    parameter int TAP_W         = TAP_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WIN_CYCLES    = WIN_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_osc,
    output logic             o_osc_en,
    output logic [TAP_W-1:0] o_tap_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_locked,
    output logic             o_fail,
    output logic [CNT_W-1:0] o_count
);

    localparam int TMR_W = timer_width(WIN_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = {TAP_W{1'b1}};

    cal_state_t       state_q,  state_nxt;
    logic [TMR_W-1:0] timer_q,  timer_nxt;
    logic [TAP_W-1:0] tap_q,    tap_nxt;
    logic [CNT_W-1:0] target_q, target_nxt;
    logic [CNT_W-1:0] count_q,  count_nxt;
    logic             locked_q, locked_nxt;
    logic             fail_q,   fail_nxt;
    logic             osc_en_q, busy_q, done_q;
    logic [CNT_W-1:0] edge_count;
    logic             cnt_clear;
    logic             cnt_enable;

    assign cnt_enable = (state_q == ST_MEASURE);
    assign cnt_clear  = (state_q != ST_MEASURE);

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_osc    (i_osc),
        .i_clear  (cnt_clear),
        .i_enable (cnt_enable),
        .o_count  (edge_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            tap_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            osc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            timer_q  <= timer_nxt;
            tap_q    <= tap_nxt;
            target_q <= target_nxt;
            count_q  <= count_nxt;
            locked_q <= locked_nxt;
            fail_q   <= fail_nxt;
            // Status outputs are registered from the next state so the analog
            // enable never sees decode glitches.
            osc_en_q <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE);
            busy_q   <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE) ||
                        (state_nxt == ST_COMPARE);
            done_q   <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt  = state_q;
        timer_nxt  = timer_q;
        tap_nxt    = tap_q;
        target_nxt = target_q;
        count_nxt  = count_q;
        locked_nxt = locked_q;
        fail_nxt   = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    target_nxt = i_target;
                    tap_nxt    = '0;
                    locked_nxt = 1'b0;
                    fail_nxt   = 1'b0;
                    timer_nxt  = SETTLE_LOAD;
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    timer_nxt = WIN_LOAD;
                    state_nxt = ST_MEASURE;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            ST_MEASURE: begin
                if (timer_q == '0) begin
                    state_nxt = ST_COMPARE;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            ST_COMPARE: begin
                count_nxt = edge_count;
                if (edge_count <= target_q) begin
                    locked_nxt = 1'b1;
                    state_nxt  = ST_DONE;
`ifdef DELAY_CAL_MARGIN_EN
                    if (tap_q != TAP_MAX) begin
                        tap_nxt = tap_q + TAP_W'(1);
                    end
`endif
                end else if (tap_q == TAP_MAX) begin
                    fail_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    tap_nxt   = tap_q + TAP_W'(1);
                    timer_nxt = SETTLE_LOAD;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_osc_en  = osc_en_q;
    assign o_tap_sel = tap_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_locked  = locked_q;
    assign o_fail    = fail_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Directed bench for delay_cal_ctrl: table of calibration runs against a ring-oscillator
// model (period 40 + 8*tap clocks, phase restarted whenever the enable drops), plus reset/start corners.
module tb_delay_cal_ctrl;

    localparam int TAP_W = 4;
    localparam int CNT_W = 12;

    logic             clk;
    logic             i_rst;
    logic             i_start;
    logic [CNT_W-1:0] i_target;
    logic             i_osc;
    logic             o_osc_en;
    logic [TAP_W-1:0] o_tap_sel;
    logic             o_busy;
    logic             o_done;
    logic             o_locked;
    logic             o_fail;
    logic [CNT_W-1:0] o_count;

    int n_vec = 0;
    int n_err = 0;

    delay_cal_ctrl #(
        .TAP_W         (TAP_W),
        .CNT_W         (CNT_W),
        .WIN_CYCLES    (256),
        .SETTLE_CYCLES (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_target  (i_target),
        .i_osc     (i_osc),
        .o_osc_en  (o_osc_en),
        .o_tap_sel (o_tap_sel),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_locked  (o_locked),
        .o_fail    (o_fail),
        .o_count   (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int osc_k      = 0;
    bit osc_stuck  = 1'b0;

    always @(negedge clk) begin
        int per;
        if (osc_stuck) begin
            i_osc = 1'b1;
        end else if (o_osc_en !== 1'b1) begin
            osc_k = 0;
            i_osc = 1'b0;
        end else begin
            osc_k = osc_k + 1;
            per   = 40 + 8 * int'(o_tap_sel);
            i_osc = ((osc_k % per) >= (per / 2));
        end
    end

    typedef struct {
        int target;
        bit stuck;
        int exp_locked;
        int exp_fail;
        int exp_tap;
        int exp_count;
        int exp_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int final_tap(input int k, input int locked);
`ifdef DELAY_CAL_MARGIN_EN
        if (locked != 0 && k < 15) return k + 1;
`endif
        return k;
    endfunction

    task automatic do_start(input int target);
        logic [31:0] t;
        t = target;
        i_start  = 1'b1;
        i_target = t[CNT_W-1:0];
        @(posedge clk); #1;
        i_start  = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int c = 1; c <= 5000; c++) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) begin
                cycles = c;
                ok     = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        bit ok;
        int dones;
        int first_done;

        //          target stuck lock fail tap count cycles
        vecs[0] = '{5,    1'b0, 1, 0, 1,  5, 522};
        vecs[1] = '{0,    1'b0, 0, 1, 15, 2, 4176};
        vecs[2] = '{4095, 1'b0, 1, 0, 0,  6, 261};
        vecs[3] = '{6,    1'b0, 1, 0, 0,  6, 261};
        vecs[4] = '{4,    1'b0, 1, 0, 3,  4, 1044};
        vecs[5] = '{3,    1'b0, 1, 0, 5,  3, 1566};
        vecs[6] = '{2,    1'b0, 1, 0, 8,  2, 2349};
        vecs[7] = '{0,    1'b1, 1, 0, 0,  0, 261};

        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_target = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk("rst_osc_en", int'(o_osc_en), 0);
        chk("rst_tap",    int'(o_tap_sel), 0);
        chk("rst_busy",   int'(o_busy), 0);
        chk("rst_done",   int'(o_done), 0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_fail",   int'(o_fail), 0);
        chk("rst_count",  int'(o_count), 0);

        for (int i = 0; i < 8; i++) begin
            osc_stuck = vecs[i].stuck;
            repeat (3) @(posedge clk);
            #1;
            do_start(vecs[i].target);
            chk($sformatf("v%0d_busy_after_start", i), int'(o_busy), 1);
            chk($sformatf("v%0d_osc_en_after_start", i), int'(o_osc_en), 1);
            chk($sformatf("v%0d_tap_reset", i), int'(o_tap_sel), 0);
            chk($sformatf("v%0d_locked_cleared", i), int'(o_locked), 0);
            chk($sformatf("v%0d_fail_cleared", i), int'(o_fail), 0);
            wait_done(cyc, ok);
            chk($sformatf("v%0d_done_seen", i), int'(ok), 1);
            chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cycles);
            chk($sformatf("v%0d_locked", i), int'(o_locked), vecs[i].exp_locked);
            chk($sformatf("v%0d_fail", i), int'(o_fail), vecs[i].exp_fail);
            chk($sformatf("v%0d_tap", i), int'(o_tap_sel),
                final_tap(vecs[i].exp_tap, vecs[i].exp_locked));
            chk($sformatf("v%0d_count", i), int'(o_count), vecs[i].exp_count);
            chk($sformatf("v%0d_osc_off_in_done", i), int'(o_osc_en), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse_1cyc", i), int'(o_done), 0);
            chk($sformatf("v%0d_idle_busy", i), int'(o_busy), 0);
            chk($sformatf("v%0d_tap_hold", i), int'(o_tap_sel),
                final_tap(vecs[i].exp_tap, vecs[i].exp_locked));
        end
        osc_stuck = 1'b0;

        // Reset in the middle of the tap-3 measurement window.
        repeat (3) @(posedge clk);
        #1;
        do_start(0);
        repeat (3 * 261 + 100) @(posedge clk);
        #1;
        chk("midrst_tap_before", int'(o_tap_sel), 3);
        chk("midrst_busy_before", int'(o_busy), 1);
        chk("midrst_count_before", int'(o_count), 5);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("midrst_osc_en", int'(o_osc_en), 0);
        chk("midrst_tap",    int'(o_tap_sel), 0);
        chk("midrst_busy",   int'(o_busy), 0);
        chk("midrst_done",   int'(o_done), 0);
        chk("midrst_locked", int'(o_locked), 0);
        chk("midrst_fail",   int'(o_fail), 0);
        chk("midrst_count",  int'(o_count), 0);
        dones = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        do_start(5);
        chk("midrst_restart_tap0", int'(o_tap_sel), 0);
        wait_done(cyc, ok);
        chk("midrst_restart_cycle", cyc, 522);
        chk("midrst_restart_tap", int'(o_tap_sel), final_tap(1, 1));
        chk("midrst_restart_count", int'(o_count), 5);

        // Start pulses while busy and during DONE must be dropped.
        repeat (3) @(posedge clk);
        #1;
        do_start(4095);
        dones      = 0;
        first_done = -1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
            i_start  = ((c < 260) && (c % 50 == 0)) || (o_done === 1'b1);
            i_target = '0;
        end
        i_start = 1'b0;
        chk("drop_start_done_count", dones, 1);
        chk("drop_start_done_cycle", first_done, 261);
        chk("drop_start_locked", int'(o_locked), 1);
        chk("drop_start_tap", int'(o_tap_sel), final_tap(0, 1));
        chk("drop_start_idle", int'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
